// File: rtl/clb_pkg.sv
`default_nettype none
// ============================================================================
// Module : clb_pkg
// Brief  : Shared constants, types and FSM encoding for the clb_ecb controller.
// Rev    : 1.0
// ============================================================================
package clb_pkg;

    localparam int CLB_ROUNDS = 30;
    localparam int CLB_LAT    = 32;
    localparam int TEXT_W     = 128;
    localparam int KEY_W      = 256;

    typedef logic [TEXT_W-1:0] text_t;
    typedef logic [KEY_W-1:0]  key_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/clb_ecb_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : clb_ecb_ctrl_if
// Brief  : Input and output valid/ready streams of the clb_ecb controller.
// Rev    : 1.0
// ============================================================================
interface clb_ecb_ctrl_if
    import clb_pkg::*;
();
    logic  in_valid;
    logic  in_ready;
    text_t in_text;
    key_t  in_key;
    logic  out_valid;
    logic  out_ready;
    text_t out_text;

    modport slave (
        input  in_valid, in_text, in_key, out_ready,
        output in_ready, out_valid, out_text
    );

    modport master (
        output in_valid, in_text, in_key, out_ready,
        input  in_ready, out_valid, out_text
    );
endinterface
`default_nettype wire

// File: rtl/clb_out_buf.sv
`default_nettype none
// ============================================================================
// Module : clb_out_buf
// Brief  : One-entry valid/ready output register; capture wins over drain.
// Rev    : 1.0
// ============================================================================
module clb_out_buf
    import clb_pkg::*;
(
    input  wire logic  clk,
    input  wire logic  rst,
    input  wire logic  capture,
    input  wire text_t cap_text,
    input  wire logic  out_ready,
    output logic       out_valid,
    output text_t      out_text,
    output logic       buf_free
);

    assign buf_free = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_text  <= '0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_text  <= cap_text;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/clb_ecb_ctrl.sv
`default_nettype none
// ============================================================================
// Module : clb_ecb_ctrl
// Brief  : Load/run/capture sequencer wrapping the clb_ecb core as a stream stage.
// Rev    : 1.0
// ============================================================================
module clb_ecb_ctrl
    import clb_pkg::*;
#(
    parameter int ROUNDS  = CLB_ROUNDS,
    parameter int TIMEOUT = 40
) (
    input  wire logic      clk,
    input  wire logic      rst,
    clb_ecb_ctrl_if.slave  bus,
    output logic           core_rst_n,
    output text_t          core_textin,
    output key_t           core_key,
    input  wire text_t     core_textout,
    input  wire logic      core_enable,
    output logic           err,
    output logic [15:0]    blk_cnt
);

    localparam int WAIT_MAX = (TIMEOUT > ROUNDS) ? TIMEOUT : ROUNDS;
    localparam int CNT_W    = $clog2(WAIT_MAX + 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_wait;
    logic             w_buf_free;
    logic             w_accept;
    logic             w_capture;

    assign bus.in_ready = (r_state == ST_IDLE);
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_capture    = (r_state == ST_RUN) && core_enable && w_buf_free;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_wait      <= '0;
            core_rst_n  <= 1'b0;
            core_textin <= '0;
            core_key    <= '0;
            err         <= 1'b0;
            blk_cnt     <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        core_textin <= bus.in_text;
                        core_key    <= bus.in_key;
                        core_rst_n  <= 1'b0;
                        r_state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    core_rst_n <= 1'b1;
                    r_wait     <= '0;
                    r_state    <= ST_RUN;
                end
                ST_RUN: begin
                    // A finished core waiting on a full buffer is not a hang.
                    if (core_enable) begin
                        if (w_buf_free) begin
                            blk_cnt    <= blk_cnt + 16'd1;
                            core_rst_n <= 1'b0;
                            r_state    <= ST_IDLE;
                        end
                    end else if (r_wait == CNT_W'(TIMEOUT - 1)) begin
                        err     <= 1'b1;
                        r_state <= ST_ERR;
                    end else begin
                        r_wait <= r_wait + CNT_W'(1);
                    end
                end
                ST_ERR: begin
                    r_state <= ST_ERR;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    clb_out_buf u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .capture   (w_capture),
        .cap_text  (core_textout),
        .out_ready (bus.out_ready),
        .out_valid (bus.out_valid),
        .out_text  (bus.out_text),
        .buf_free  (w_buf_free)
    );

endmodule
`default_nettype wire

// File: tb/tb_clb_ecb_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_clb_ecb_ctrl
// Brief  : Directed bench for clb_ecb_ctrl against a behavioural 30-round core.
// Rev    : 1.0
// ============================================================================
module tb_clb_ecb_ctrl;
    import clb_pkg::*;

    localparam int ROUNDS  = 30;
    localparam int TIMEOUT = 40;

    typedef struct {
        text_t text;
        key_t  key;
        text_t exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_rst_n;
    text_t       core_textin;
    key_t        core_key;
    text_t       core_textout;
    logic        core_enable;
    logic        err;
    logic [15:0] blk_cnt;

    int  tests = 0;
    int  fails = 0;
    int  cyc   = 0;
    bit  core_hang = 1'b0;
    bit  mon_en    = 1'b0;
    text_t outq[$];
    logic [5:0] core_cnt;
    vec_t vecs[10];

    clb_ecb_ctrl_if ifc ();

    clb_ecb_ctrl #(.ROUNDS(ROUNDS), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (ifc),
        .core_rst_n   (core_rst_n),
        .core_textin  (core_textin),
        .core_key     (core_key),
        .core_textout (core_textout),
        .core_enable  (core_enable),
        .err          (err),
        .blk_cnt      (blk_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in cipher: any fixed keyed mixing suffices to tell blocks apart.
    function automatic text_t enc(text_t t, key_t k);
        return {t[63:0], t[127:64]} ^ k[255:128] ^ ~k[127:0];
    endfunction

    always @(posedge clk) begin
        if (!core_rst_n)              core_cnt <= '0;
        else if (core_cnt < ROUNDS)   core_cnt <= core_cnt + 6'd1;
    end
    assign core_enable  = (core_cnt == 6'(ROUNDS)) && !core_hang;
    assign core_textout = core_enable ? enc(core_textin, core_key) : '0;

    always @(negedge clk)
        if (mon_en && ifc.out_valid && ifc.out_ready) outq.push_back(ifc.out_text);

    task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ifc.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send(text_t t, key_t k, bit hold, output int acc);
        bit ok;
        @(negedge clk);
        ifc.in_text  = t;
        ifc.in_key   = k;
        ifc.in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (ifc.in_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        acc = cyc;
        if (!hold) ifc.in_valid = 1'b0;
    endtask

    // Returns the number of rising edges from call until out_valid is seen.
    task automatic wait_ov(output int lat);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (ifc.out_valid) begin lat = k; break; end
        end
        if (lat < 0) chk("out_valid_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        int lat, acc, base;
        int accs[10];
        text_t t_a, t_b;
        bit seen;

        ifc.in_valid  = 1'b0;
        ifc.in_text   = '0;
        ifc.in_key    = '0;
        ifc.out_ready = 1'b1;

        vecs[0].text = 128'h0123456789abcdeffedcba9876543210;
        vecs[0].key  = '0;
        for (int i = 1; i < 10; i++) begin
            vecs[i].text = {32'hA5A50000 + 32'(i), 32'h5A5A5A5A ^ 32'(i * 7),
                            32'h13579BDF + 32'(i << 8), 32'hFFFF0000 | 32'(i)};
            vecs[i].key  = {64'h0F0F0F0F0F0F0F0F * 64'(i), 64'hDEADBEEF00000000 + 64'(i),
                            64'h1122334455667788 ^ 64'(i), 64'(i) << 32};
        end
        for (int i = 0; i < 10; i++) vecs[i].exp = enc(vecs[i].text, vecs[i].key);

        // Reset values
        do_reset();
        #1;
        chk("rst_in_ready",    ifc.in_ready,  1);
        chk("rst_core_rst_n",  core_rst_n,    0);
        chk("rst_out_valid",   ifc.out_valid, 0);
        chk("rst_out_text",    ifc.out_text,  0);
        chk("rst_core_textin", core_textin,   0);
        chk("rst_core_key",    core_key,      0);
        chk("rst_err",         err,           0);
        chk("rst_blk_cnt",     blk_cnt,       0);

        // Single block latency and result
        send(vecs[0].text, vecs[0].key, 1'b0, acc);
        chk("t0_core_rst_n_low",  core_rst_n,  0);
        chk("t0_core_textin",     core_textin, vecs[0].text);
        @(posedge clk); #1;
        chk("t1_core_rst_n_high", core_rst_n,  1);
        wait_ov(lat);
        chk("single_latency", lat + 1, CLB_LAT);
        chk("single_text",    ifc.out_text, vecs[0].exp);
        chk("single_blk_cnt", blk_cnt, 1);
        @(posedge clk); #1;
        chk("single_drained", ifc.out_valid, 0);

        // Ten back-to-back blocks, in_valid held high
        do_reset();
        base   = outq.size();
        mon_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].text, vecs[i].key, 1'b1, accs[i]);
        end
        ifc.in_valid = 1'b0;
        for (int k = 0; k < 100 && outq.size() < base + 10; k++) @(posedge clk);
        #1;
        mon_en = 1'b0;
        chk("b2b_count", outq.size() - base, 10);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) chk($sformatf("b2b_interval_%0d", i), accs[i] - accs[i-1], 33);
            if (base + i < outq.size())
                chk($sformatf("b2b_text_%0d", i), outq[base + i], vecs[i].exp);
        end
        chk("b2b_blk_cnt", blk_cnt, 10);

        // Back-pressure: second block stalls behind an unconsumed first result
        do_reset();
        ifc.out_ready = 1'b0;
        t_a = vecs[3].exp;
        t_b = vecs[4].exp;
        send(vecs[3].text, vecs[3].key, 1'b0, acc);
        wait_ov(lat);
        send(vecs[4].text, vecs[4].key, 1'b0, acc);
        repeat (48) @(posedge clk);
        #1;
        chk("bp_out_valid",  ifc.out_valid, 1);
        chk("bp_hold_text",  ifc.out_text,  t_a);
        chk("bp_err",        err,           0);
        chk("bp_in_ready",   ifc.in_ready,  0);
        chk("bp_blk_cnt",    blk_cnt,       1);
        chk("bp_core_run",   core_rst_n,    1);
        @(negedge clk);
        ifc.out_ready = 1'b1;
        chk("bp_drain_text", ifc.out_text, t_a);
        @(posedge clk); #1;
        chk("bp_cap_valid",  ifc.out_valid, 1);
        chk("bp_cap_text",   ifc.out_text,  t_b);
        chk("bp_cap_cnt",    blk_cnt,       2);
        @(posedge clk); #1;
        chk("bp_cap_drained", ifc.out_valid, 0);

        // Hung core: timeout on the 40th enable-low RUN cycle
        do_reset();
        core_hang = 1'b1;
        send(vecs[5].text, vecs[5].key, 1'b0, acc);
        for (int k = 1; k <= 41; k++) begin
            @(posedge clk); #1;
            if (k == 40) chk("hang_err_before", err, 0);
        end
        chk("hang_err",      err,          1);
        chk("hang_in_ready", ifc.in_ready, 0);
        @(negedge clk);
        ifc.in_text  = vecs[6].text;
        ifc.in_key   = vecs[6].key;
        ifc.in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("hang_in_ready_held", ifc.in_ready, 0);
        chk("hang_textin_held",   core_textin,  vecs[5].text);
        chk("hang_no_output",     ifc.out_valid, 0);
        core_hang = 1'b0;
        do_reset();
        #1;
        chk("hang_rst_err",      err,          0);
        chk("hang_rst_in_ready", ifc.in_ready, 1);

        // Asynchronous reset mid-RUN
        send(vecs[7].text, vecs[7].key, 1'b0, acc);
        repeat (16) @(posedge clk);
        #1;
        chk("mid_core_running", core_rst_n, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_core_rst_n_async", core_rst_n, 0);
        chk("mid_out_valid",        ifc.out_valid, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (ifc.out_valid) seen = 1'b1;
        end
        chk("mid_no_partial", seen, 0);
        send(vecs[8].text, vecs[8].key, 1'b0, acc);
        wait_ov(lat);
        chk("mid_new_latency", lat, CLB_LAT);
        chk("mid_new_text",    ifc.out_text, vecs[8].exp);
        chk("mid_new_blk_cnt", blk_cnt, 1);

        // Block counter wrap
        do_reset();
        @(negedge clk);
        force dut.blk_cnt = 16'hFFFF;
        #1;
        release dut.blk_cnt;
        #1;
        chk("wrap_preload", blk_cnt, 16'hFFFF);
        send(vecs[9].text, vecs[9].key, 1'b0, acc);
        wait_ov(lat);
        chk("wrap_text",    ifc.out_text, vecs[9].exp);
        chk("wrap_blk_cnt", blk_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
